pipe_mac_controller: RTL and testbench
======================================

Name: pipe_mac_controller

Overview:
- Sequencing controller for the pipelined multiply-accumulate datapath: multiply register, then accumulate register whose sum is restarted by a registered partial-sum-done flag.
- Per start: walks the input-feature and filter scratchpads and produces NUM_OUTPUTS partial sums of FILTER_SIZE products each.
- Drives ld_mult, ld_add, par_done and pipe_stall, and owns the output valid/ready handshake so a finished sum is never overwritten before it is accepted.

Parameters:
FILTER_SIZE, 4, products per partial sum (>=1)
NUM_OUTPUTS, 8, partial sums per start (>=1)
STRIDE, 1, IF address step between consecutive partial sums
IF_ADDR_W, 6, IF scratchpad address width
FILTER_ADDR_W, 4, filter scratchpad address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a run; sampled only in IDLE
if_valid  input  1  IF scratchpad data at if_addr is valid this cycle
filter_valid  input  1  filter data at filter_addr is valid this cycle
out_ready  input  1  downstream accepts the accumulator value
if_addr  output  IF_ADDR_W  IF read address (asynchronous-read scratchpad)
filter_addr  output  FILTER_ADDR_W  filter read address
if_rd_en  output  1  IF operand consumed this cycle
filter_rd_en  output  1  filter operand consumed this cycle
ld_mult  output  1  capture product into multiply register
ld_add  output  1  update accumulate register
par_done  output  1  first term of a new sum (datapath registers it, aligned with ld_add)
pipe_stall  output  1  busy cycle with no issue
out_valid  output  1  accumulator holds a finished sum
busy  output  1  not IDLE
done  output  1  one-cycle end-of-run pulse

Behaviour:
- Reset (rst=0, any time, including mid-run): state IDLE, counters cleared, in-flight flags cleared. All outputs 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN next cycle with term=0, sum_idx=0. start is ignored outside IDLE.
- Addresses: if_addr = (sum_idx*STRIDE + term) mod 2^IF_ADDR_W. filter_addr = term. Both are held while not issuing.
- Issue condition in RUN: if_valid & filter_valid & ~block.
- On issue:
  - ld_mult=1, if_rd_en=1, filter_rd_en=1.
  - par_done = (term==0).
  - term increments.
  - If term==FILTER_SIZE-1: term wraps to 0 and sum_idx increments. If sum_idx==NUM_OUTPUTS-1, go to DRAIN.
- ld_add: ld_mult delayed exactly one cycle, unconditionally.
- last_flight: register set for one cycle after issuing term FILTER_SIZE-1 (the cycle of that sum's final ld_add).
- out_valid:
  - Set the cycle after last_flight.
  - Held until out_valid & out_ready.
  - Latency from last-term issue to out_valid is 2 cycles.
- block = (term==0) & (last_flight | (out_valid & ~out_ready)). The first term of a new sum may issue in the same cycle as the handshake. Minimum inter-sum bubble is 1 cycle (FILTER_SIZE+1 cycles per sum at full rate).
- pipe_stall = 1 in RUN/DRAIN/DONE cycles with ld_mult=0; 0 in IDLE.
- DRAIN: no issue. When ~last_flight & out_valid & out_ready -> DONE.
- DONE: done=1, busy=1 for one cycle -> IDLE.
- busy = 1 in RUN, DRAIN and DONE.
- Simultaneous events: a valid drop on a last-term cycle means no issue and no counter change. FILTER_SIZE=1 makes every issue both first and last term (par_done=1 each issue).

Test Plan:
- Nominal (FS=4, N=2, STRIDE=1; valids and out_ready held 1; start at cycle 0) -> issue cycles 1-4 with if_addr 0,1,2,3 and par_done at 1; ld_add 2-5; out_valid 6; issue 6-9 with if_addr 1,2,3,4 and par_done at 6; out_valid 11; done at 12; busy=0 at 13.
- if_valid=0 in cycle 2 -> ld_mult=0, pipe_stall=1, if_addr held at 1; ld_add absent in cycle 3; first out_valid moves to cycle 7.
- out_ready=0 during cycles 6-8 -> out_valid held 6-8, no ld_mult, pipe_stall=1; accept and first issue of sum 2 both at cycle 9.
- FS=1, N=3 -> par_done=1 on every issue; issues at cycles 1, 3, 5; out_valid at 3, 5, 7; done at 8.
- rst=0 at cycle 3 of a run -> all outputs 0 immediately; a later start restarts at if_addr 0 with par_done=1.
- start pulsed at cycle 4 while busy -> no effect; same sequence as the nominal case.

Source files
------------

// File: rtl/pipe_mac_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mac_controller
// Description : Sequencer for a multiply/accumulate pipeline that issues
//               scratchpad reads and owns the partial-sum output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mac_controller #(
  parameter int FILTER_SIZE   = 4,
  parameter int NUM_OUTPUTS   = 8,
  parameter int STRIDE        = 1,
  parameter int IF_ADDR_W     = 6,
  parameter int FILTER_ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     if_valid,
  input  logic                     filter_valid,
  input  logic                     out_ready,
  output logic [IF_ADDR_W-1:0]     if_addr,
  output logic [FILTER_ADDR_W-1:0] filter_addr,
  output logic                     if_rd_en,
  output logic                     filter_rd_en,
  output logic                     ld_mult,
  output logic                     ld_add,
  output logic                     par_done,
  output logic                     pipe_stall,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int c_term_w = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int c_sum_w  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [c_term_w-1:0]  c_term_last = c_term_w'(FILTER_SIZE - 1);
  localparam logic [c_sum_w-1:0]   c_sum_last  = c_sum_w'(NUM_OUTPUTS - 1);
  localparam logic [IF_ADDR_W-1:0] c_stride    = IF_ADDR_W'(STRIDE);

  logic [1:0]           r_state;
  logic [c_term_w-1:0]  r_term;
  logic [c_sum_w-1:0]   r_sum_idx;
  logic [IF_ADDR_W-1:0] r_if_base;
  logic                 r_ld_add;
  logic                 r_last_flight;
  logic                 r_out_valid;

  logic w_first_term;
  logic w_last_term;
  logic w_last_sum;
  logic w_handshake;
  logic w_block;
  logic w_issue;

  assign w_first_term = (r_term == '0);
  assign w_last_term  = (r_term == c_term_last);
  assign w_last_sum   = (r_sum_idx == c_sum_last);
  assign w_handshake  = r_out_valid & out_ready;

  // A new sum may not start while the previous one is still landing in the
  // accumulator or is finished but not yet accepted downstream.
  assign w_block = w_first_term & (r_last_flight | (r_out_valid & ~out_ready));
  assign w_issue = (r_state == c_st_run) & if_valid & filter_valid & ~w_block;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= c_st_idle;
      r_term        <= '0;
      r_sum_idx     <= '0;
      r_if_base     <= '0;
      r_ld_add      <= 1'b0;
      r_last_flight <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_ld_add      <= w_issue;
      r_last_flight <= w_issue & w_last_term;

      if (r_last_flight) begin
        r_out_valid <= 1'b1;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state   <= c_st_run;
            r_term    <= '0;
            r_sum_idx <= '0;
            r_if_base <= '0;
          end
        end
        c_st_run: begin
          if (w_issue) begin
            if (w_last_term) begin
              r_term    <= '0;
              r_sum_idx <= r_sum_idx + c_sum_w'(1);
              r_if_base <= r_if_base + c_stride;
              if (w_last_sum) begin
                r_state <= c_st_drain;
              end
            end else begin
              r_term <= r_term + c_term_w'(1);
            end
          end
        end
        c_st_drain: begin
          // Wait for the final sum to land and be accepted.
          if (!r_last_flight && w_handshake) begin
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign if_addr      = r_if_base + IF_ADDR_W'(r_term);
  assign filter_addr  = FILTER_ADDR_W'(r_term);
  assign ld_mult      = w_issue;
  assign if_rd_en     = w_issue;
  assign filter_rd_en = w_issue;
  assign par_done     = w_issue & w_first_term;
  assign ld_add       = r_ld_add;
  assign out_valid    = r_out_valid;
  assign busy         = (r_state != c_st_idle);
  assign done         = (r_state == c_st_done);
  assign pipe_stall   = busy & ~w_issue;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mac_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mac_controller
// Description : Directed cycle-by-cycle bench for pipe_mac_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mac_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic if_valid = 1'b0;
  logic filter_valid = 1'b0;
  logic out_ready = 1'b0;

  logic [5:0] if_addr_a, if_addr_b;
  logic [3:0] filter_addr_a, filter_addr_b;
  logic if_rd_en_a, filter_rd_en_a, ld_mult_a, ld_add_a, par_done_a;
  logic pipe_stall_a, out_valid_a, busy_a, done_a;
  logic if_rd_en_b, filter_rd_en_b, ld_mult_b, ld_add_b, par_done_b;
  logic pipe_stall_b, out_valid_b, busy_b, done_b;

  logic [8:0] ctl_a, ctl_b;
  assign ctl_a = {ld_mult_a, ld_add_a, par_done_a, out_valid_a, done_a,
                  busy_a, pipe_stall_a, if_rd_en_a, filter_rd_en_a};
  assign ctl_b = {ld_mult_b, ld_add_b, par_done_b, out_valid_b, done_b,
                  busy_b, pipe_stall_b, if_rd_en_b, filter_rd_en_b};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_mac_controller #(
    .FILTER_SIZE(4), .NUM_OUTPUTS(2), .STRIDE(1), .IF_ADDR_W(6), .FILTER_ADDR_W(4)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .if_valid(if_valid),
    .filter_valid(filter_valid), .out_ready(out_ready),
    .if_addr(if_addr_a), .filter_addr(filter_addr_a),
    .if_rd_en(if_rd_en_a), .filter_rd_en(filter_rd_en_a),
    .ld_mult(ld_mult_a), .ld_add(ld_add_a), .par_done(par_done_a),
    .pipe_stall(pipe_stall_a), .out_valid(out_valid_a), .busy(busy_a), .done(done_a)
  );

  pipe_mac_controller #(
    .FILTER_SIZE(1), .NUM_OUTPUTS(3), .STRIDE(1), .IF_ADDR_W(6), .FILTER_ADDR_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .if_valid(if_valid),
    .filter_valid(filter_valid), .out_ready(out_ready),
    .if_addr(if_addr_b), .filter_addr(filter_addr_b),
    .if_rd_en(if_rd_en_b), .filter_rd_en(filter_rd_en_b),
    .ld_mult(ld_mult_b), .ld_add(ld_add_b), .par_done(par_done_b),
    .pipe_stall(pipe_stall_b), .out_valid(out_valid_b), .busy(busy_b), .done(done_b)
  );

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_checks++;
    if ({ctl_a, if_addr_a, filter_addr_a} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_a: got %b expected all zero", {ctl_a, if_addr_a, filter_addr_a});
    end
    n_checks++;
    if ({ctl_b, if_addr_b, filter_addr_b} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_b: got %b expected all zero", {ctl_b, if_addr_b, filter_addr_b});
    end
    repeat (2) @(negedge clk);
    if_valid = 1'b1; filter_valid = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
  endtask

  // Order of bits: ld_mult ld_add par_done out_valid done busy stall if_rd filt_rd
  task automatic test_nominal();
    logic [31:0] m = 32'h03DE, a = 32'h07BC, p = 32'h0042, v = 32'h0840;
    logic [31:0] d = 32'h1000, b = 32'h1FFE, s = 32'h1C20;
    int addr_tab[8] = '{0, 1, 2, 3, 1, 2, 3, 4};
    int k = 0;
    logic [8:0] want;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start_a = (c == 0); if_valid = 1'b1; filter_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      want = {m[c], a[c], p[c], v[c], d[c], b[c], s[c], m[c], m[c]};
      n_checks++;
      if (ctl_a !== want) begin
        n_errors++;
        $display("FAIL nominal_ctl cycle %0d: got %b expected %b", c, ctl_a, want);
      end
      if (m[c]) begin
        n_checks++;
        if ({if_addr_a, filter_addr_a} !== {6'(addr_tab[k]), 4'(k % 4)}) begin
          n_errors++;
          $display("FAIL nominal_addr cycle %0d: got if=%0d f=%0d expected if=%0d f=%0d",
                   c, if_addr_a, filter_addr_a, addr_tab[k], k % 4);
        end
        k++;
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [31:0] m = 32'h07BA, a = 32'h0F74, p = 32'h0082, v = 32'h1080;
    logic [31:0] d = 32'h2000, b = 32'h3FFE, s = 32'h3844;
    int addr_tab[8] = '{0, 1, 2, 3, 1, 2, 3, 4};
    int k = 0;
    logic [8:0] want;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      start_a = (c == 0); if_valid = (c != 2); filter_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      want = {m[c], a[c], p[c], v[c], d[c], b[c], s[c], m[c], m[c]};
      n_checks++;
      if (ctl_a !== want) begin
        n_errors++;
        $display("FAIL valid_drop_ctl cycle %0d: got %b expected %b", c, ctl_a, want);
      end
      if (c == 2) begin
        n_checks++;
        if (if_addr_a !== 6'd1) begin
          n_errors++;
          $display("FAIL valid_drop_hold cycle 2: got if=%0d expected if=1", if_addr_a);
        end
      end
      if (m[c]) begin
        n_checks++;
        if ({if_addr_a, filter_addr_a} !== {6'(addr_tab[k]), 4'(k % 4)}) begin
          n_errors++;
          $display("FAIL valid_drop_addr cycle %0d: got if=%0d f=%0d expected if=%0d f=%0d",
                   c, if_addr_a, filter_addr_a, addr_tab[k], k % 4);
        end
        k++;
      end
    end
    if_valid = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [31:0] m = 32'h1E1E, a = 32'h3C3C, p = 32'h0202, v = 32'h43C0;
    logic [31:0] d = 32'h8000, b = 32'hFFFE, s = 32'hE1E0;
    int addr_tab[8] = '{0, 1, 2, 3, 1, 2, 3, 4};
    int k = 0;
    logic [8:0] want;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      start_a = (c == 0); if_valid = 1'b1; filter_valid = 1'b1;
      out_ready = !(c >= 6 && c <= 8);
      @(negedge clk);
      want = {m[c], a[c], p[c], v[c], d[c], b[c], s[c], m[c], m[c]};
      n_checks++;
      if (ctl_a !== want) begin
        n_errors++;
        $display("FAIL backpressure_ctl cycle %0d: got %b expected %b", c, ctl_a, want);
      end
      if (m[c]) begin
        n_checks++;
        if ({if_addr_a, filter_addr_a} !== {6'(addr_tab[k]), 4'(k % 4)}) begin
          n_errors++;
          $display("FAIL backpressure_addr cycle %0d: got if=%0d f=%0d expected if=%0d f=%0d",
                   c, if_addr_a, filter_addr_a, addr_tab[k], k % 4);
        end
        k++;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_filter_size_one();
    logic [31:0] m = 32'h002A, a = 32'h0054, p = 32'h002A, v = 32'h00A8;
    logic [31:0] d = 32'h0100, b = 32'h01FE, s = 32'h01D4;
    int k = 0;
    logic [8:0] want;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start_b = (c == 0); if_valid = 1'b1; filter_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      want = {m[c], a[c], p[c], v[c], d[c], b[c], s[c], m[c], m[c]};
      n_checks++;
      if (ctl_b !== want) begin
        n_errors++;
        $display("FAIL fs1_ctl cycle %0d: got %b expected %b", c, ctl_b, want);
      end
      if (m[c]) begin
        n_checks++;
        if ({if_addr_b, filter_addr_b} !== {6'(k), 4'd0}) begin
          n_errors++;
          $display("FAIL fs1_addr cycle %0d: got if=%0d f=%0d expected if=%0d f=0",
                   c, if_addr_b, filter_addr_b, k);
        end
        k++;
      end
    end
    start_b = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start_a = (c == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ctl_a, if_addr_a, filter_addr_a} !== 19'd0) begin
      n_errors++;
      $display("FAIL midrun_reset: got %b expected all zero", {ctl_a, if_addr_a, filter_addr_a});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      start_a = (c == 0);
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({ld_mult_a, par_done_a, if_addr_a} !== {1'b1, 1'b1, 6'd0}) begin
          n_errors++;
          $display("FAIL restart_first: got lm=%b pd=%b if=%0d expected lm=1 pd=1 if=0",
                   ld_mult_a, par_done_a, if_addr_a);
        end
      end
      if (c == 2) begin
        n_checks++;
        if ({ld_mult_a, par_done_a, if_addr_a} !== {1'b1, 1'b0, 6'd1}) begin
          n_errors++;
          $display("FAIL restart_second: got lm=%b pd=%b if=%0d expected lm=1 pd=0 if=1",
                   ld_mult_a, par_done_a, if_addr_a);
        end
      end
      if (c == 12 || c == 13) begin
        n_checks++;
        if ({done_a, busy_a} !== ((c == 12) ? 2'b11 : 2'b00)) begin
          n_errors++;
          $display("FAIL restart_end cycle %0d: got done,busy=%b expected %b",
                   c, {done_a, busy_a}, (c == 12) ? 2'b11 : 2'b00);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] m = 32'h03DE, a = 32'h07BC, p = 32'h0042, v = 32'h0840;
    logic [31:0] d = 32'h1000, b = 32'h1FFE, s = 32'h1C20;
    int addr_tab[8] = '{0, 1, 2, 3, 1, 2, 3, 4};
    int k = 0;
    logic [8:0] want;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start_a = (c == 0 || c == 4);
      @(negedge clk);
      want = {m[c], a[c], p[c], v[c], d[c], b[c], s[c], m[c], m[c]};
      n_checks++;
      if (ctl_a !== want) begin
        n_errors++;
        $display("FAIL start_ignored_ctl cycle %0d: got %b expected %b", c, ctl_a, want);
      end
      if (m[c]) begin
        n_checks++;
        if ({if_addr_a, filter_addr_a} !== {6'(addr_tab[k]), 4'(k % 4)}) begin
          n_errors++;
          $display("FAIL start_ignored_addr cycle %0d: got if=%0d f=%0d expected if=%0d f=%0d",
                   c, if_addr_a, filter_addr_a, addr_tab[k], k % 4);
        end
        k++;
      end
    end
    start_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_valid_drop();
    test_backpressure();
    test_filter_size_one();
    test_reset_mid_run();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
